// File: rtl/alu_result_checker.sv
// Checks an ALU result/zero pair against an independently recomputed expected value.
// Shift ops are replayed one bit per cycle so the shifter is not checked against a copy of itself.
module alu_result_checker #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_input,
  input  logic [31:0]      b_input,
  input  logic [4:0]       sa,
  input  logic [3:0]       opcode,
  input  logic [31:0]      resultado,
  input  logic             zero,
  output logic             done,
  output logic             pass,
  output logic             skipped,
  output logic [31:0]      expected,
  output logic [ERR_W-1:0] err_count
);

  // Handshake: a transaction transfers on the rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid seen while busy is ignored (no queuing).
  typedef enum logic [1:0] {IDLE, SHIFT, CMP} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1111;

  state_t      state, state_next;
  logic [31:0] work;
  logic [31:0] res_q;
  logic [4:0]  cnt;
  logic [3:0]  op_q;
  logic        zero_q;
  logic        unsup_q;
  logic        accept;
  logic        is_shift;
  logic        supported;
  logic [31:0] calc;
  logic        fail;

  assign accept = in_valid && in_ready;
  assign fail   = (res_q != work) || (zero_q != (work == 32'd0));

  always_comb begin
    calc      = 32'd0;
    supported = 1'b1;
    is_shift  = 1'b0;
    case (opcode)
      OP_AND: calc = a_input & b_input;
      OP_OR:  calc = a_input | b_input;
      OP_ADD: calc = a_input + b_input;
      OP_XOR: calc = a_input ^ b_input;
      OP_SUB: calc = a_input - b_input;
      OP_SLT: calc = {31'd0, $signed(a_input) < $signed(b_input)};
      OP_NOR: calc = ~(a_input | b_input);
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default: supported = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = (is_shift && sa != 5'd0) ? SHIFT : CMP;
      end
      // Counter is never 0 in SHIFT, so the last shift step is the one taken at cnt==1.
      SHIFT: if (cnt == 5'd1) state_next = CMP;
      CMP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= 32'd0;
      res_q     <= 32'd0;
      cnt       <= 5'd0;
      op_q      <= 4'd0;
      zero_q    <= 1'b0;
      unsup_q   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      skipped   <= 1'b0;
      expected  <= 32'd0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q    <= opcode;
          res_q   <= resultado;
          zero_q  <= zero;
          unsup_q <= !supported;
          cnt     <= sa;
          work    <= is_shift ? b_input : calc;
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          case (op_q)
            OP_SLL:  work <= {work[30:0], 1'b0};
            OP_SRL:  work <= {1'b0, work[31:1]};
            default: work <= {work[31], work[31:1]};
          endcase
        end
        CMP: begin
          done     <= 1'b1;
          expected <= work;
          skipped  <= unsup_q;
          if (unsup_q) begin
            pass <= 1'b1;
          end else begin
            pass <= !fail;
            if (fail && err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: hand-computed vectors, latency, saturation,
// back-to-back hold of in_valid and asynchronous abort of a running shift.
module tb_alu_result_checker;

  localparam int ERR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a_input, b_input, resultado;
  logic [4:0]       sa;
  logic [3:0]       opcode;
  logic             zero;
  logic             done, pass, skipped;
  logic [31:0]      expected;
  logic [ERR_W-1:0] err_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  alu_result_checker #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_input(a_input), .b_input(b_input), .sa(sa), .opcode(opcode),
    .resultado(resultado), .zero(zero), .done(done), .pass(pass),
    .skipped(skipped), .expected(expected), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input logic [31:0] r, input logic z);
    opcode = op; a_input = a; b_input = b; sa = s; resultado = r; zero = z;
  endtask

  // Called one step after a rising edge with the DUT idle.
  task automatic txn(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] s, input logic [31:0] r,
                     input logic z, input logic [31:0] exp_val, input logic exp_pass,
                     input logic exp_skip, input int exp_lat, input int exp_err);
    int n;
    check({tag, "_ready"}, in_ready, 1'b1);
    drive(op, a, b, s, r, z);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive($urandom_range(15, 0), $urandom, $urandom, $urandom_range(31, 0), $urandom, 1'b0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_skip"}, skipped, exp_skip);
    check({tag, "_err"}, err_count, exp_err);
    if (!exp_skip) check({tag, "_exp"}, expected, exp_val);
    check({tag, "_ready_done"}, in_ready, 1'b1);
  endtask

  initial begin
    int n, dones;
    rst_n = 1'b0;
    in_valid = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_skip", skipped, 1'b0);
    check("rst_exp", expected, 32'd0);
    check("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_done", done, 1'b0);

    // SRA sweep with sign replication
    txn("sra0", 4'b1111, 32'd0, 32'hFFFFFFFE, 5'd0, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1, 0, 1, 0);
    txn("sra1", 4'b1111, 32'd0, 32'hFFFFFFFE, 5'd1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1, 0, 2, 0);
    txn("sra2", 4'b1111, 32'd0, 32'hFFFFFFFE, 5'd2, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1, 0, 3, 0);
    txn("sra3", 4'b1111, 32'd0, 32'hFFFFFFFE, 5'd3, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1, 0, 4, 0);
    txn("sra_pos", 4'b1111, 32'd0, 32'h40000000, 5'd4, 32'h04000000, 1'b0, 32'h04000000, 1, 0, 5, 0);
    txn("sll31", 4'b1000, 32'd0, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 32'h80000000, 1, 0, 32, 0);
    txn("srl31", 4'b1001, 32'd0, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 32'h00000001, 1, 0, 32, 0);
    txn("srl3", 4'b1001, 32'd0, 32'hF0000000, 5'd3, 32'h1E000000, 1'b0, 32'h1E000000, 1, 0, 4, 0);

    // Arithmetic and logic ops
    txn("add_wrap", 4'b0010, 32'h7FFFFFFF, 32'd1, 5'd7, 32'h80000000, 1'b0, 32'h80000000, 1, 0, 1, 0);
    txn("sub_wrap", 4'b0110, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1, 0, 1, 0);
    txn("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'd0, 5'd0, 32'd1, 1'b0, 32'd1, 1, 0, 1, 0);
    txn("slt_pos", 4'b0111, 32'd5, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 32'd0, 1, 0, 1, 0);
    txn("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 32'hF000F000, 1, 0, 1, 0);
    txn("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0, 32'hFFF0FFF0, 1, 0, 1, 0);
    txn("xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0, 32'h0FF00FF0, 1, 0, 1, 0);
    txn("nor", 4'b1100, 32'h0000000F, 32'h000000F0, 5'd0, 32'hFFFFFF00, 1'b0, 32'hFFFFFF00, 1, 0, 1, 0);
    txn("and_zero", 4'b0000, 32'h0000000F, 32'h000000F0, 5'd0, 32'd0, 1'b1, 32'd0, 1, 0, 1, 0);

    // Mismatches, unsupported opcode, saturation
    txn("mis_add", 4'b0010, 32'd2, 32'd2, 5'd0, 32'd5, 1'b0, 32'd4, 0, 0, 1, 1);
    txn("mis_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0, 32'd0, 0, 0, 1, 2);
    txn("unsup", 4'b0100, 32'd1, 32'd2, 5'd0, 32'd9, 1'b0, 32'd0, 1, 1, 1, 2);
    txn("sat_a", 4'b0010, 32'd1, 32'd1, 5'd0, 32'd0, 1'b1, 32'd2, 0, 0, 1, 3);
    txn("sat_b", 4'b1000, 32'd0, 32'd1, 5'd2, 32'd2, 1'b0, 32'd4, 0, 0, 3, 3);
    txn("sat_ok", 4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 32'd2, 1, 0, 1, 3);

    // in_valid held high across a 31-step shift: exactly one accept per done
    exp_q.push_back(32'h80000000);
    exp_q.push_back(32'd7);
    drive(4'b1000, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(4'b0010, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    n = 0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      n++;
      if (n == 33) in_valid = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) check("b2b_first_lat", n, 32);
        if (dones == 2) check("b2b_second_lat", n, 34);
        if (exp_q.size() != 0) check("b2b_exp", expected, exp_q.pop_front());
      end
    end
    check("b2b_dones", dones, 2);
    check("b2b_left", exp_q.size(), 0);

    // Asynchronous abort of a running shift
    drive(4'b1000, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", in_ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_err", err_count, 0);
    check("abort_pass", pass, 1'b0);
    check("abort_exp", expected, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    txn("post_abort", 4'b0010, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 32'd30, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
